// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: 2-way set-associative cache controller with per-set LRU, write-back and line refill.
module cache_ctrl_2way #(
  parameter int ADDR_WIDTH       = 5,
  parameter int TAG_BITS         = 23,
  parameter int WHOLE_DATA_WIDTH = 128,
  parameter int BANK_DATA_WIDTH  = 32,
  parameter int DATA_WORD_NUM    = 4,
  parameter int DATA_BYTE_NUM    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_addr,
  input  logic [BANK_DATA_WIDTH-1:0]  cpu_wdata,
  input  logic [DATA_BYTE_NUM-1:0]    cpu_byte_en,
  output logic [BANK_DATA_WIDTH-1:0]  cpu_rdata,
  output logic                        cpu_ready,
  output logic                        c_wr_en,
  output logic                        c_refill,
  output logic [ADDR_WIDTH-1:0]       c_addr,
  output logic [TAG_BITS-1:0]         c_tag,
  output logic [1:0]                  c_way_select,
  output logic [WHOLE_DATA_WIDTH-1:0] c_wr_data,
  output logic [DATA_WORD_NUM-1:0]    c_wr_word_en,
  output logic [DATA_BYTE_NUM-1:0]    c_wr_byte_en,
  input  logic [1:0]                  c_valid,
  input  logic [1:0]                  c_hit,
  input  logic [1:0]                  c_modify,
  input  logic [TAG_BITS-1:0]         c_tag_way0,
  input  logic [TAG_BITS-1:0]         c_tag_way1,
  input  logic [WHOLE_DATA_WIDTH-1:0] c_rd_data_way0,
  input  logic [WHOLE_DATA_WIDTH-1:0] c_rd_data_way1,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [WHOLE_DATA_WIDTH-1:0] mem_wdata,
  input  logic                        mem_ack,
  input  logic [WHOLE_DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, COMPARE = 2'd1, WRITEBACK = 2'd2, ALLOCATE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [(1<<ADDR_WIDTH)-1:0] lru_q, lru_d;
  logic req_we_q, req_we_d, victim_q, victim_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [BANK_DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_BYTE_NUM-1:0] req_be_q, req_be_d;
  logic [1:0] hit_v;
  logic hit, hit_way, victim_c, unused_bits;
  logic [WHOLE_DATA_WIDTH-1:0] hit_data;
  logic [1:0] word;
  assign c_addr = req_addr_q[4 +: ADDR_WIDTH];
  assign c_tag = req_addr_q[31 -: TAG_BITS];
  assign word = req_addr_q[3:2];
  assign unused_bits = ^req_addr_q[1:0];
  assign hit_v = c_hit & c_valid;
  assign hit = |hit_v;
  assign hit_way = ~hit_v[0];
  assign hit_data = hit_way ? c_rd_data_way1 : c_rd_data_way0;
  // fill an empty way before evicting anything; otherwise follow LRU
  assign victim_c = ~c_valid[0] ? 1'b0 : ~c_valid[1] ? 1'b1 : lru_q[c_addr];
  always_comb begin
    state_d = state_q;
    lru_d = lru_q;
    req_we_d = req_we_q;
    req_addr_d = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d = req_be_q;
    victim_d = victim_q;
    cpu_rdata = '0;
    cpu_ready = 1'b0;
    c_wr_en = 1'b0;
    c_refill = 1'b0;
    c_way_select = 2'b00;
    c_wr_data = '0;
    c_wr_word_en = '0;
    c_wr_byte_en = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: if (cpu_req) begin
        state_d = COMPARE;
        req_we_d = cpu_we;
        req_addr_d = cpu_addr;
        req_wdata_d = cpu_wdata;
        req_be_d = cpu_byte_en;
      end
      COMPARE: if (hit) begin
        cpu_ready = 1'b1;
        cpu_rdata = req_we_q ? '0 : hit_data[{word, 5'b0} +: BANK_DATA_WIDTH];
        c_wr_en = req_we_q;
        c_way_select = req_we_q ? (hit_way ? 2'b10 : 2'b01) : 2'b00;
        c_wr_word_en = req_we_q ? DATA_WORD_NUM'(1) << word : '0;
        c_wr_byte_en = req_we_q ? req_be_q : '0;
        c_wr_data = req_we_q ? {DATA_WORD_NUM{req_wdata_q}} : '0;
        lru_d[c_addr] = ~hit_way;
        state_d = IDLE;
      end else begin
        victim_d = victim_c;
        state_d = (c_valid[victim_c] & c_modify[victim_c]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = {victim_q ? c_tag_way1 : c_tag_way0, c_addr, 4'b0};
        mem_wdata = victim_q ? c_rd_data_way1 : c_rd_data_way0;
        state_d = mem_ack ? ALLOCATE : WRITEBACK;
      end
      default: begin
        mem_req = 1'b1;
        mem_addr = {c_tag, c_addr, 4'b0};
        c_wr_en = mem_ack;
        c_refill = mem_ack;
        c_way_select = mem_ack ? (victim_q ? 2'b10 : 2'b01) : 2'b00;
        c_wr_word_en = mem_ack ? '1 : '0;
        c_wr_byte_en = mem_ack ? '1 : '0;
        c_wr_data = mem_ack ? mem_rdata : '0;
        state_d = mem_ack ? COMPARE : ALLOCATE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lru_q <= '0;
      req_we_q <= 1'b0;
      req_addr_q <= '0;
      req_wdata_q <= '0;
      req_be_q <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lru_q <= lru_d;
      req_we_q <= req_we_d;
      req_addr_q <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q <= req_be_d;
      victim_q <= victim_d;
    end
  end
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb_cache_ctrl_2way: directed bench with a behavioural 2-way data/tag array and a hand-driven memory port.
module tb_cache_ctrl_2way;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata, mem_addr;
  logic [3:0] cpu_byte_en = '0, c_wr_word_en, c_wr_byte_en;
  logic cpu_ready, c_wr_en, c_refill, mem_req, mem_we, mem_ack = 1'b0;
  logic [4:0] c_addr;
  logic [22:0] c_tag, c_tag_way0, c_tag_way1;
  logic [1:0] c_way_select, c_valid, c_hit, c_modify;
  logic [127:0] c_wr_data, c_rd_data_way0, c_rd_data_way1, mem_wdata, mem_rdata = '0;
  int n_tot = 0, n_pass = 0;
  logic vld[2][32], mdf[2][32];
  logic [22:0] tg[2][32];
  logic [127:0] dat[2][32];
  localparam logic [127:0] L0 = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
  localparam logic [127:0] L1 = 128'h11114444_11113333_11112222_11111111;
  localparam logic [127:0] L2 = 128'h22224444_22223333_22222222_22221111;
  localparam logic [127:0] L3 = 128'h33334444_33333333_33332222_33331111;

  cache_ctrl_2way dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .c_wr_en(c_wr_en), .c_refill(c_refill), .c_addr(c_addr), .c_tag(c_tag),
    .c_way_select(c_way_select), .c_wr_data(c_wr_data), .c_wr_word_en(c_wr_word_en),
    .c_wr_byte_en(c_wr_byte_en), .c_valid(c_valid), .c_hit(c_hit), .c_modify(c_modify),
    .c_tag_way0(c_tag_way0), .c_tag_way1(c_tag_way1), .c_rd_data_way0(c_rd_data_way0),
    .c_rd_data_way1(c_rd_data_way1), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign c_valid = {vld[1][c_addr], vld[0][c_addr]};
  assign c_modify = {mdf[1][c_addr], mdf[0][c_addr]};
  assign c_hit = {tg[1][c_addr] == c_tag, tg[0][c_addr] == c_tag};
  assign c_tag_way0 = tg[0][c_addr];
  assign c_tag_way1 = tg[1][c_addr];
  assign c_rd_data_way0 = dat[0][c_addr];
  assign c_rd_data_way1 = dat[1][c_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 32; s++) begin
          vld[w][s] <= 1'b0;
          mdf[w][s] <= 1'b0;
          tg[w][s] <= '0;
          dat[w][s] <= '0;
        end
    end else if (c_wr_en) begin
      for (int w = 0; w < 2; w++)
        if (c_way_select[w]) begin
          if (c_refill) begin
            dat[w][c_addr] <= c_wr_data;
            tg[w][c_addr] <= c_tag;
            vld[w][c_addr] <= 1'b1;
            mdf[w][c_addr] <= 1'b0;
          end else begin
            for (int k = 0; k < 4; k++)
              for (int b = 0; b < 4; b++)
                if (c_wr_word_en[k] && c_wr_byte_en[b])
                  dat[w][c_addr][k*32+b*8 +: 8] <= c_wr_data[k*32+b*8 +: 8];
            mdf[w][c_addr] <= 1'b1;
          end
        end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    cpu_byte_en = be;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int cnt, output logic [31:0] rd);
    cnt = 0;
    while (!cpu_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("cpu_ready_seen", cpu_ready, 1'b1);
    rd = cpu_rdata;
    cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_mem();
    int n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mem_req_seen", mem_req, 1'b1);
  endtask

  task automatic mem_respond(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                             input logic [127:0] rd, input int dly, input logic [1:0] way);
    wait_mem();
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, addr);
    if (we) chk("mem_wdata", mem_wdata, wd);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("mem_req_hold", mem_req, 1'b1);
      chk("mem_addr_hold", mem_addr, addr);
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    #1;
    if (!we) begin
      chk("refill_wr_en", {c_wr_en, c_refill, c_wr_word_en, c_wr_byte_en}, {2'b11, 8'hFF});
      chk("refill_way", c_way_select, way);
      chk("refill_data", c_wr_data, rd);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] rd;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_mem", {mem_req, mem_we, mem_addr}, '0);
    chk("rst_c", {c_wr_en, c_refill, c_addr, c_tag, c_way_select, c_wr_word_en, c_wr_byte_en}, '0);
    chk("rst_rdata", cpu_rdata, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    // cold load: empty set 4, refill way0
    issue(1'b0, 32'h40, '0, '0);
    mem_respond(1'b0, 32'h40, '0, L0, 0, 2'b01);
    wait_ready(cnt, rd);
    chk("cold_latency", cnt, 0);
    chk("cold_rdata", rd, 32'h0000AAAA);
    // store hit word1 low bytes
    issue(1'b1, 32'h44, 32'h12345678, 4'b0011);
    chk("st_ready", cpu_ready, 1'b1);
    chk("st_ctl", {c_wr_en, c_refill, c_way_select, mem_req}, 5'b10010);
    chk("st_word_en", c_wr_word_en, 4'b0010);
    chk("st_byte_en", c_wr_byte_en, 4'b0011);
    chk("st_wdata", c_wr_data, {4{32'h12345678}});
    wait_ready(cnt, rd);
    issue(1'b0, 32'h44, '0, '0);
    chk("ld_hit_1cyc", cpu_ready, 1'b1);
    wait_ready(cnt, rd);
    chk("ld_merged", rd, 32'h00005678);
    // fill way1 with tag 1, dirty it, then touch way0
    issue(1'b0, 32'h240, '0, '0);
    mem_respond(1'b0, 32'h240, '0, L1, 0, 2'b10);
    wait_ready(cnt, rd);
    chk("way1_rdata", rd, 32'h11111111);
    issue(1'b1, 32'h240, 32'hCAFEF00D, 4'hF);
    wait_ready(cnt, rd);
    issue(1'b0, 32'h40, '0, '0);
    wait_ready(cnt, rd);
    chk("touch_way0", rd, 32'h0000AAAA);
    // tag 2 miss evicts dirty way1, slow ack on write-back
    issue(1'b0, 32'h440, '0, '0);
    mem_respond(1'b1, 32'h240, {L1[127:32], 32'hCAFEF00D}, '0, 5, 2'b00);
    mem_respond(1'b0, 32'h440, '0, L2, 0, 2'b10);
    wait_ready(cnt, rd);
    chk("wb_miss_rdata", rd, 32'h22221111);
    // touch way0 again so clean way1 (tag 2) is the victim
    issue(1'b0, 32'h4C, '0, '0);
    wait_ready(cnt, rd);
    chk("touch_way0_w3", rd, 32'h0000DDDD);
    issue(1'b0, 32'h648, '0, '0);
    mem_respond(1'b0, 32'h640, '0, L3, 2, 2'b10);
    wait_ready(cnt, rd);
    chk("clean_miss_rdata", rd, 32'h33333333);
    // spurious ack while idle
    mem_ack = 1'b1;
    #1;
    chk("spur_outs", {mem_req, cpu_ready, c_wr_en}, 3'b000);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("spur_still_idle", {mem_req, cpu_ready}, 2'b00);
    issue(1'b0, 32'h64C, '0, '0);
    chk("spur_then_hit", cpu_ready, 1'b1);
    wait_ready(cnt, rd);
    chk("spur_hit_rdata", rd, 32'h33334444);
    // reset while writing back dirty way0
    issue(1'b0, 32'h840, '0, '0);
    wait_mem();
    chk("rst_wb_we", mem_we, 1'b1);
    chk("rst_wb_addr", mem_addr, 32'h40);
    rst = 1'b1;
    #1;
    chk("rst_wb_mem_req", mem_req, 1'b0);
    chk("rst_wb_ready", cpu_ready, 1'b0);
    chk("rst_wb_req_clr", c_addr, '0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {cpu_ready, mem_req}, 2'b00);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
